serial_frame_arbiter: RTL and testbench
=======================================

Name: serial_frame_arbiter

Overview:
- Shares the serial display shift chain (six digits × 8 bits, data/latch pair) between two frame requesters:
  - requester 0: time display frame.
  - requester 1: auxiliary frame, e.g. set-mode blink or test pattern.
- Each granted frame is shifted out MSB-first, followed by a latch pulse and an inter-frame gap.
- Runs entirely in the serial shift clock domain and sits between the frame producers and the serial output pins.

Parameters:
- SHIFT_WIDTH, 48: bits per frame; must be ≥ 2.
- LATCH_CYCLES, 1: cycles o_serial_latch is held high; must be ≥ 1.
- GAP_CYCLES, 2: idle cycles after latch before the next grant; must be ≥ 1.

Ports:
- o_serial_clk  input  1  Clock: serial shift clock; all state changes on its rising edge.
- i_reset_n  input  1  Synchronous reset, active-low.
- i_valid0  input  1  Requester 0 has a frame pending.
- i_frame0  input  SHIFT_WIDTH  Requester 0 frame; bit SHIFT_WIDTH-1 is shifted first.
- o_ready0  output  1  Requester 0 frame accepted this cycle.
- i_valid1  input  1  Requester 1 has a frame pending.
- i_frame1  input  SHIFT_WIDTH  Requester 1 frame.
- o_ready1  output  1  Requester 1 frame accepted this cycle.
- o_serial_data  output  1  Serial data to the shift chain.
- o_shift_en  output  1  High while o_serial_data carries a valid frame bit.
- o_serial_latch  output  1  Latch strobe to the shift chain.
- o_busy  output  1  High whenever state ≠ IDLE.
- o_grant_id  output  1  Requester owning the current or most recent frame.
- o_done  output  1  One-cycle pulse when a frame completes.

Behaviour:
- Reset is synchronous (i_reset_n low at a rising edge of o_serial_clk) and sets:
  - state = IDLE, bit counter = 0, shift register = 0.
  - o_serial_data, o_shift_en, o_serial_latch, o_busy, o_grant_id, o_done = 0.
  - RR pointer (optional feature) = favour requester 0.
- Reset during SHIFT, LATCH or GAP abandons the frame. No latch pulse is issued for it and o_done does not pulse.
- States: IDLE → SHIFT → LATCH → GAP → IDLE.
- IDLE:
  - o_readyN is combinational: (state == IDLE) & grantN.
  - Fixed priority: requester 0 wins when both valid.
  - When either valid is high, the handshake occurs in the same cycle (valid & ready).
  - At that edge: shift register ← granted frame; o_grant_id ← winner; counter ← 0; state ← SHIFT.
  - At most one ready is high in any cycle.
  - A ready is never high outside IDLE.
- Requester obligations:
  - Hold valid and frame stable until ready.
  - Dropping valid before ready withdraws the request with no side effects.
- SHIFT:
  - Lasts exactly SHIFT_WIDTH cycles.
  - o_serial_data = shift_reg[SHIFT_WIDTH-1]; o_shift_en = 1.
  - Each edge: shift register shifts left (zero fill) and the counter increments.
  - Cycle k presents frame bit SHIFT_WIDTH-1-k.
  - When counter = SHIFT_WIDTH-1: state ← LATCH, counter ← 0.
- LATCH:
  - Lasts exactly LATCH_CYCLES cycles.
  - o_serial_latch = 1; o_serial_data = 0; o_shift_en = 0.
  - Then state ← GAP.
- GAP:
  - Lasts exactly GAP_CYCLES cycles; all serial outputs are 0.
  - o_done = 1 in the first GAP cycle only.
  - Then state ← IDLE.
- Frame period (accept edge to next possible accept) = 1 + SHIFT_WIDTH + LATCH_CYCLES + GAP_CYCLES cycles. With defaults: 52 cycles.
- The counter is wide enough for max(SHIFT_WIDTH, LATCH_CYCLES, GAP_CYCLES) and never wraps within a state.
- o_grant_id holds its value through IDLE until the next grant.
- Requests arriving during busy states wait; no request is lost while valid is held.

Optional Feature:
- Macro: SERIAL_FRAME_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer records the last granted requester.
  - When both are valid in IDLE, the requester not granted last wins.
  - A single valid requester always wins.
  - The pointer updates only on an accepted handshake.
  - After reset, the first contended grant goes to requester 0.
- Undefined: fixed priority, requester 0 always wins; no pointer logic is present.

Test Plan:
- Reset, then i_valid0 = 1 with i_frame0 = 48'hA5C3_0F00_FF81:
  - o_ready0 is high in the same cycle.
  - 48 o_shift_en cycles follow with data 1,0,1,0,0,1,0,1,… MSB-first.
  - o_serial_latch is high for 1 cycle, then o_done pulses in the next cycle.
  - A 48-bit shift/latch bench model captures 48'hA5C3_0F00_FF81.
- i_valid0 and i_valid1 both high continuously, fixed priority:
  - Every grant goes to requester 0; o_ready1 is never high.
  - Consecutive accepts are exactly 52 cycles apart.
- Same stimulus with SERIAL_FRAME_ARB_RR_EN defined: o_grant_id sequence is 0,1,0,1; each requester's frame is captured intact.
- i_valid1 asserted mid-SHIFT of a requester 0 frame:
  - o_ready1 stays low until IDLE.
  - It is then granted on the first IDLE cycle and o_grant_id = 1.
- i_reset_n low for 1 cycle at bit 20 of a frame:
  - Next cycle: all outputs are 0 and state is IDLE.
  - No latch pulse and no o_done for that frame.
  - A following request is shifted from bit 47.
- i_valid0 pulsed high only during SHIFT, then low before IDLE: no grant, no extra frame, o_busy drops after GAP.

Source files
------------

// File: rtl/serial_frame_arbiter.sv
// Arbitrates two frame requesters onto the serial display shift chain (shift, latch, gap).
// Define SERIAL_FRAME_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has priority.
module serial_frame_arbiter #(
    parameter int unsigned SHIFT_WIDTH  = 48,
    parameter int unsigned LATCH_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic                   o_serial_clk,
    input  logic                   i_reset_n,
    input  logic                   i_valid0,
    input  logic [SHIFT_WIDTH-1:0] i_frame0,
    output logic                   o_ready0,
    input  logic                   i_valid1,
    input  logic [SHIFT_WIDTH-1:0] i_frame1,
    output logic                   o_ready1,
    output logic                   o_serial_data,
    output logic                   o_shift_en,
    output logic                   o_serial_latch,
    output logic                   o_busy,
    output logic                   o_grant_id,
    output logic                   o_done
);

    localparam int unsigned MaxLg  = (LATCH_CYCLES > GAP_CYCLES) ? LATCH_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxCnt = (SHIFT_WIDTH > MaxLg) ? SHIFT_WIDTH : MaxLg;
    localparam int unsigned CntW   = (MaxCnt > 2) ? $clog2(MaxCnt) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StLatch, StGap} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   grant_id_q, grant_id_d;
    logic                   pick1;
    logic                   accept;

`ifdef SERIAL_FRAME_ARB_RR_EN
    // last_q holds the most recent winner; reset to 1 so the first contended grant goes to 0.
    logic last_q;

    always_comb begin
        pick1 = i_valid1 & (~i_valid0 | ~last_q);
    end

    always_ff @(posedge o_serial_clk) begin
        if (!i_reset_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= pick1;
        end
    end
`else
    always_comb begin
        pick1 = i_valid1 & ~i_valid0;
    end
`endif

    always_comb begin
        o_ready0 = (state_q == StIdle) & i_valid0 & ~pick1;
        o_ready1 = (state_q == StIdle) & pick1;
        accept   = o_ready0 | o_ready1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        grant_id_d = grant_id_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d    = pick1 ? i_frame1 : i_frame0;
                    grant_id_d = pick1;
                    cnt_d      = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                shift_d = {shift_q[SHIFT_WIDTH-2:0], 1'b0};
                if (cnt_q == CntW'(SHIFT_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = StLatch;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLatch: begin
                if (cnt_q == CntW'(LATCH_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge o_serial_clk) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            grant_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            grant_id_q <= grant_id_d;
        end
    end

    always_comb begin
        o_shift_en     = (state_q == StShift);
        o_serial_data  = (state_q == StShift) & shift_q[SHIFT_WIDTH-1];
        o_serial_latch = (state_q == StLatch);
        o_busy         = (state_q != StIdle);
        o_done         = (state_q == StGap) & (cnt_q == '0);
        o_grant_id     = grant_id_q;
    end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Directed bench for serial_frame_arbiter with a bit/frame scoreboard fed at each accept.
module tb_serial_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic [47:0] frame0 = '0, frame1 = '0;
    logic        ready0, ready1, sdata, shift_en, slatch, busy, grant_id, done;

    serial_frame_arbiter dut (
        .o_serial_clk  (clk),
        .i_reset_n     (rst_n),
        .i_valid0      (valid0),
        .i_frame0      (frame0),
        .o_ready0      (ready0),
        .i_valid1      (valid1),
        .i_frame1      (frame1),
        .o_ready1      (ready1),
        .o_serial_data (sdata),
        .o_shift_en    (shift_en),
        .o_serial_latch(slatch),
        .o_busy        (busy),
        .o_grant_id    (grant_id),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          latch_cnt = 0;
    int          done_cnt = 0;
    logic        mon_en = 1'b0;
    logic        bit_q[$];
    logic [47:0] frame_q[$];
    logic [47:0] model = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) bit_q.push_back(f[i]);
        frame_q.push_back(f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns when a ready is seen (before the accepting edge); which = -1 on timeout.
    task automatic wait_accept(output int which, output int stamp);
        which = -1;
        stamp = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (ready0 || ready1) begin
                which = ready1 ? 1 : 0;
                stamp = cyc;
                break;
            end
            @(posedge clk);
        end
        if (which < 0) check("accept_timeout", 48'd0, 48'd1);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && busy; i++) tick();
        if (busy) check("idle_timeout", 48'd1, 48'd0);
    endtask

    // Scoreboard monitor: compares each shifted bit and the captured frame at latch.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ready_while_busy", 48'(busy & (ready0 | ready1)), 48'd0);
            check("ready_both", 48'(ready0 & ready1), 48'd0);
            if (shift_en) begin
                if (bit_q.size() == 0) begin
                    check("unexpected_shift", 48'd1, 48'd0);
                end else begin
                    check("serial_data", 48'(sdata), 48'(bit_q.pop_front()));
                end
                model = {model[46:0], sdata};
            end else begin
                check("data_idle_zero", 48'(sdata), 48'd0);
            end
            if (slatch) begin
                latch_cnt++;
                if (frame_q.size() == 0) check("unexpected_latch", 48'd1, 48'd0);
                else check("captured_frame", model, frame_q.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int which, stamp, prev, exp_w, lc, dc;
        logic [47:0] fa, fb;

        // Reset
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_shift_en", 48'(shift_en), 48'd0);
        check("rst_latch", 48'(slatch), 48'd0);
        check("rst_data", 48'(sdata), 48'd0);
        check("rst_grant_id", 48'(grant_id), 48'd0);
        check("rst_done", 48'(done), 48'd0);
        check("rst_ready", 48'({ready0, ready1}), 48'd0);
        mon_en = 1'b1;
        tick();

        // Single frame from requester 0
        valid0 = 1'b1;
        frame0 = 48'hA5C3_0F00_FF81;
        #1;
        check("t1_ready0", 48'(ready0), 48'd1);
        check("t1_ready1", 48'(ready1), 48'd0);
        push_frame(frame0);
        tick();
        valid0 = 1'b0;
        check("t1_busy", 48'(busy), 48'd1);
        check("t1_grant", 48'(grant_id), 48'd0);
        for (int k = 0; k < 48; k++) begin
            check("t1_shift_en", 48'(shift_en), 48'd1);
            tick();
        end
        check("t1_latch", 48'(slatch), 48'd1);
        check("t1_latch_se", 48'(shift_en), 48'd0);
        check("t1_latch_done", 48'(done), 48'd0);
        tick();
        check("t1_latch_end", 48'(slatch), 48'd0);
        check("t1_done", 48'(done), 48'd1);
        tick();
        check("t1_done_once", 48'(done), 48'd0);
        check("t1_gap_busy", 48'(busy), 48'd1);
        tick();
        check("t1_idle", 48'(busy), 48'd0);
        check("t1_latch_count", 48'(latch_cnt), 48'd1);
        check("t1_done_count", 48'(done_cnt), 48'd1);
        check("t1_bits_left", 48'(bit_q.size()), 48'd0);

        // Contention: both requesters valid continuously
        fa = 48'h1234_5678_9ABC;
        fb = 48'hFEDC_BA98_7654;
        valid0 = 1'b1;
        valid1 = 1'b1;
        frame0 = fa;
        frame1 = fb;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
`ifdef SERIAL_FRAME_ARB_RR_EN
            exp_w = g % 2;
`else
            exp_w = 0;
`endif
            wait_accept(which, stamp);
            check("cont_winner", 48'(which), 48'(exp_w));
            if (g > 0) check("cont_period", 48'(stamp - prev), 48'd52);
            prev = stamp;
            push_frame(exp_w == 1 ? fb : fa);
            tick();
            check("cont_grant_id", 48'(grant_id), 48'(exp_w));
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        wait_idle();

        // Requester 1 arrives mid-shift
        valid0 = 1'b1;
        frame0 = 48'h0F0F_3C3C_8001;
        wait_accept(which, stamp);
        check("mid_first", 48'(which), 48'd0);
        prev = stamp;
        push_frame(frame0);
        tick();
        valid0 = 1'b0;
        repeat (10) tick();
        valid1 = 1'b1;
        frame1 = 48'hC001_D00D_5A5A;
        for (int i = 0; i < 100 && busy; i++) begin
            #1;
            check("mid_ready1_low", 48'(ready1), 48'd0);
            tick();
        end
        wait_accept(which, stamp);
        check("mid_second", 48'(which), 48'd1);
        check("mid_first_idle", 48'(stamp - prev), 48'd52);
        push_frame(frame1);
        tick();
        valid1 = 1'b0;
        check("mid_grant_id", 48'(grant_id), 48'd1);
        wait_idle();

        // Reset at bit 20 of a frame
        valid0 = 1'b1;
        frame0 = 48'h8421_7BDE_6699;
        wait_accept(which, stamp);
        push_frame(frame0);
        tick();
        valid0 = 1'b0;
        repeat (20) tick();
        lc = latch_cnt;
        dc = done_cnt;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bit_q.delete();
        frame_q.delete();
        check("rr_busy", 48'(busy), 48'd0);
        check("rr_outputs", 48'({sdata, shift_en, slatch, grant_id, done}), 48'd0);
        repeat (60) tick();
        check("rr_no_latch", 48'(latch_cnt), 48'(lc));
        check("rr_no_done", 48'(done_cnt), 48'(dc));
        valid0 = 1'b1;
        frame0 = 48'hF00D_CAFE_1357;
        wait_accept(which, stamp);
        check("rr_next_winner", 48'(which), 48'd0);
        push_frame(frame0);
        tick();
        valid0 = 1'b0;
        wait_idle();
        check("rr_next_latch", 48'(latch_cnt), 48'(lc + 1));

        // Requester 0 pulses only while busy: withdrawn, no grant
        valid1 = 1'b1;
        frame1 = 48'h2468_ACE0_1357;
        wait_accept(which, stamp);
        check("wd_first", 48'(which), 48'd1);
        push_frame(frame1);
        tick();
        valid1 = 1'b0;
        lc = latch_cnt;
        repeat (5) tick();
        valid0 = 1'b1;
        frame0 = 48'hDEAD_BEEF_0000;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("wd_ready0_low", 48'(ready0), 48'd0);
            tick();
        end
        valid0 = 1'b0;
        wait_idle();
        repeat (60) tick();
        check("wd_busy_low", 48'(busy), 48'd0);
        check("wd_one_frame", 48'(latch_cnt), 48'(lc + 1));
        check("wd_bits_left", 48'(bit_q.size()), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
